// File: rtl/neuron_rr_sched_if.sv
// Request/result bus of neuron_rr_sched: per-requester input vectors in, tagged ReLU results out.
interface neuron_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*64-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic               q_valid;
    logic               q_ready;
    logic [7:0]         q;
    logic [IDW-1:0]     q_tag;

    modport master (output req, din, q_ready, input gnt, q_valid, q, q_tag);
    modport slave  (input req, din, q_ready, output gnt, q_valid, q, q_tag);
endinterface

// File: rtl/neuron_rr_sched.sv
// Round-robin time-sharing of one 8-input ReLU neuron among NREQ requesters.
// Two-stage pipe: operand register (A) feeding a tagged output register (B).
module neuron_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    neuron_rr_sched_if.slave bus,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);
    logic            a_vld_q, a_vld_d;
    logic [63:0]     a_vec_q, a_vec_d;
    logic [IDW-1:0]  a_tag_q, a_tag_d;
    logic            b_vld_q, b_vld_d;
    logic [7:0]      q_q, q_d;
    logic [IDW-1:0]  q_tag_q, q_tag_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            b_adv, b_free, a_adv, a_free;
    logic            grant;
    int              idx;
    int              win_idx;
    logic [IDW-1:0]  win;
    logic [NREQ-1:0] gnt;
    logic [10:0]     sum;

    assign b_adv  = b_vld_q & bus.q_ready;
    assign b_free = ~b_vld_q | b_adv;
    assign a_adv  = a_vld_q & b_free;
    assign a_free = ~a_vld_q | a_adv;

    // Grant search starts at ptr_q and wraps; gated by rst_n so GNT is 0 during reset.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant   = 1'b0;
        idx     = 0;
        win_idx = 0;
        gnt     = '0;
        if (a_free && rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (int'(ptr_q) + i) % NREQ;
                if (!grant && bus.req[idx]) begin
                    grant   = 1'b1;
                    win_idx = idx;
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    assign win = IDW'(win_idx);

    always_comb begin
        sum = '0;
        for (int k = 0; k < 8; k++) begin
            sum = sum + {3'b000, a_vec_q[8*k +: 8]};
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        a_vld_d = a_vld_q;
        a_vec_d = a_vec_q;
        a_tag_d = a_tag_q;
        b_vld_d = b_vld_q;
        q_d     = q_q;
        q_tag_d = q_tag_q;
        cnt_d   = cnt_q;

        if (a_adv) begin
            a_vld_d = 1'b0;
        end
        if (grant) begin
            a_vld_d = 1'b1;
            a_vec_d = bus.din[win_idx*64 +: 64];
            a_tag_d = win;
            ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        end

        // A sum of 1024 or more is treated as a negative activation and clamps to 0.
        if (a_adv) begin
            b_vld_d = 1'b1;
            q_d     = sum[10] ? 8'd0 : 8'(sum >> 2);
            q_tag_d = a_tag_q;
        end else if (b_adv) begin
            b_vld_d = 1'b0;
        end

        if (b_adv && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            ptr_q   <= '0;
            a_vld_q <= 1'b0;
            a_vec_q <= '0;
            a_tag_q <= '0;
            b_vld_q <= 1'b0;
            q_q     <= '0;
            q_tag_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            a_vld_q <= a_vld_d;
            a_vec_q <= a_vec_d;
            a_tag_q <= a_tag_d;
            b_vld_q <= b_vld_d;
            q_q     <= q_d;
            q_tag_q <= q_tag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.q_valid = b_vld_q;
    assign bus.q       = q_q;
    assign bus.q_tag   = q_tag_q;
    assign busy        = a_vld_q | b_vld_q;
    assign op_count    = cnt_q;
endmodule

// File: tb/tb_neuron_rr_sched.sv
// Directed bench for neuron_rr_sched: ReLU values, round-robin order, backpressure, reset, saturation.
module tb_neuron_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    neuron_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    neuron_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) sbus ();

    logic            busy;
    logic [CNTW-1:0] op_count;
    logic            sbusy;
    logic [3:0]      sop_count;

    neuron_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    neuron_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(4)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (sbus),
        .busy     (sbusy),
        .op_count (sop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fill(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic set_vec(input int r, input logic [63:0] vec);
        bus.din[r*64 +: 64] = vec;
    endtask

    // One requester alone through an empty pipe: grant, operand stage, result, acceptance.
    task automatic single(input int r, input logic [63:0] vec, input logic [7:0] exp_q,
                          input logic [CNTW-1:0] exp_cnt);
        set_vec(r, vec);
        bus.req = NREQ'(1) << r;
        #1 chk("single_gnt", 64'(bus.gnt), 64'(NREQ'(1) << r));
        tick();
        bus.req = '0;
        chk("single_busy_a", 64'(busy), 64'd1);
        chk("single_nvalid", 64'(bus.q_valid), 64'd0);
        tick();
        chk("single_valid", 64'(bus.q_valid), 64'd1);
        chk("single_q", 64'(bus.q), 64'(exp_q));
        chk("single_tag", 64'(bus.q_tag), 64'(r));
        tick();
        chk("single_cnt", 64'(op_count), 64'(exp_cnt));
        chk("single_drain", 64'(bus.q_valid), 64'd0);
        chk("single_idle", 64'(busy), 64'd0);
    endtask

    logic [7:0] rr_res [4];

    initial begin
        rst_n        = 1'b0;
        bus.req      = 4'b0001;
        bus.din      = '0;
        bus.q_ready  = 1'b0;
        sbus.req     = '0;
        sbus.din     = '0;
        sbus.q_ready = 1'b1;

        // Reset state, with a request pending that must not be granted.
        #3;
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_valid", 64'(bus.q_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(op_count), 64'd0);
        chk("rst_q", 64'(bus.q), 64'd0);
        chk("rst_tag", 64'(bus.q_tag), 64'd0);
        bus.req = '0;
        tick();
        #2 rst_n = 1'b1;
        bus.q_ready = 1'b1;
        tick();

        // Single-requester results: 800->200, then ReLU boundaries.
        single(0, fill(8'd100), 8'd200, 16'd1);
        single(0, 64'h0000_0000_0000_0003, 8'd0, 16'd2);
        single(1, fill(8'd127), 8'd254, 16'd3);
        single(2, fill(8'd128), 8'd0, 16'd4);
        single(0, {8'd131, {7{8'd127}}}, 8'd255, 16'd5);
        single(3, fill(8'hff), 8'd0, 16'd6);

        // All requesting, full throughput: grants 0,1,2,3,0.
        set_vec(0, fill(8'd4));
        set_vec(1, fill(8'd8));
        set_vec(2, fill(8'd16));
        set_vec(3, fill(8'd64));
        rr_res[0] = 8'd8;
        rr_res[1] = 8'd16;
        rr_res[2] = 8'd32;
        rr_res[3] = 8'd128;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_gnt", 64'(bus.gnt), 64'(4'b0001 << (k % 4)));
            if (k == 1) chk("rr_nvalid", 64'(bus.q_valid), 64'd0);
            if (k >= 2) begin
                chk("rr_valid", 64'(bus.q_valid), 64'd1);
                chk("rr_tag", 64'(bus.q_tag), 64'((k - 2) % 4));
                chk("rr_q", 64'(bus.q), 64'(rr_res[(k - 2) % 4]));
            end
            tick();
        end
        bus.req = '0;
        chk("rr_tag_l3", 64'(bus.q_tag), 64'd3);
        chk("rr_q_l3", 64'(bus.q), 64'd128);
        tick();
        chk("rr_tag_l0", 64'(bus.q_tag), 64'd0);
        chk("rr_q_l0", 64'(bus.q), 64'd8);
        tick();
        chk("rr_drain", 64'(bus.q_valid), 64'd0);
        chk("rr_cnt", 64'(op_count), 64'd11);

        // Backpressure: pointer at 1, two grants fill the pipe, then stall.
        bus.q_ready = 1'b0;
        bus.req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_gnt", 64'(bus.gnt), (k == 0) ? 64'h2 : (k == 1) ? 64'h4 : 64'h0);
            if (k >= 2) begin
                chk("bp_valid", 64'(bus.q_valid), 64'd1);
                chk("bp_tag", 64'(bus.q_tag), 64'd1);
                chk("bp_q", 64'(bus.q), 64'd16);
                chk("bp_busy", 64'(busy), 64'd1);
            end
            tick();
        end
        chk("bp_tag_hold", 64'(bus.q_tag), 64'd1);
        chk("bp_q_hold", 64'(bus.q), 64'd16);
        bus.q_ready = 1'b1;
        #1 chk("bp_resume_gnt", 64'(bus.gnt), 64'h8);
        tick();
        bus.req = '0;
        chk("bp_tag2", 64'(bus.q_tag), 64'd2);
        chk("bp_q2", 64'(bus.q), 64'd32);
        tick();
        chk("bp_tag3", 64'(bus.q_tag), 64'd3);
        chk("bp_q3", 64'(bus.q), 64'd128);
        tick();
        chk("bp_drain", 64'(bus.q_valid), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_cnt", 64'(op_count), 64'd14);

        // Reset with both stages occupied and the pointer moved to 2.
        bus.q_ready = 1'b0;
        set_vec(0, fill(8'd100));
        set_vec(1, fill(8'd8));
        set_vec(2, fill(8'd1));
        bus.req = 4'b0001;
        #1 chk("mr_gnt0", 64'(bus.gnt), 64'h1);
        tick();
        bus.req = 4'b0110;
        #1 chk("mr_gnt1", 64'(bus.gnt), 64'h2);
        tick();
        chk("mr_valid", 64'(bus.q_valid), 64'd1);
        chk("mr_q", 64'(bus.q), 64'd200);
        chk("mr_gnt_full", 64'(bus.gnt), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_valid", 64'(bus.q_valid), 64'd0);
        chk("mr_rst_gnt", 64'(bus.gnt), 64'h0);
        chk("mr_rst_busy", 64'(busy), 64'd0);
        chk("mr_rst_cnt", 64'(op_count), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        bus.q_ready = 1'b1;
        #1;
        chk("mr_post_gnt", 64'(bus.gnt), 64'h2);
        chk("mr_post_valid", 64'(bus.q_valid), 64'd0);
        chk("mr_post_busy", 64'(busy), 64'd0);
        tick();
        bus.req = '0;
        chk("mr_a_busy", 64'(busy), 64'd1);
        chk("mr_no_stale", 64'(bus.q_valid), 64'd0);
        tick();
        chk("mr_res_valid", 64'(bus.q_valid), 64'd1);
        chk("mr_res_q", 64'(bus.q), 64'd16);
        chk("mr_res_tag", 64'(bus.q_tag), 64'd1);
        tick();
        chk("mr_res_cnt", 64'(op_count), 64'd1);
        chk("mr_res_drain", 64'(bus.q_valid), 64'd0);

        // 4-bit counter instance: continuous results, count saturates at 15.
        sbus.req = 4'b0001;
        for (int k = 0; k < 22; k++) begin
            tick();
            chk("sat_cnt", 64'(sop_count), (k < 1) ? 64'd0 : (k - 1 > 15) ? 64'd15 : 64'(k - 1));
        end
        chk("sat_valid", 64'(sbus.q_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
